// File: rtl/code_conv_sched_if.sv
// Request/result bundle for the shared binary/Gray converter.
// slave side is the scheduler; master side is the requesters plus the result consumer.
interface code_conv_sched_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req0_mode;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic             req1_mode;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             out_valid;
  logic             out_id;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;

  modport slave (
    input  req0_valid, req0_mode, req0_data,
    input  req1_valid, req1_mode, req1_data,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_id, out_data, busy
  );

  modport master (
    output req0_valid, req0_mode, req0_data,
    output req1_valid, req1_mode, req1_data,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_id, out_data, busy
  );
endinterface

// File: rtl/code_conv_sched.sv
// Round-robin scheduler for one shared binary<->Gray engine; bin->Gray 1 cycle, Gray->bin WIDTH cycles.
// One request in flight; result holds in DONE until out_ready, requests are only taken in IDLE.
module code_conv_sched #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  code_conv_sched_if.slave   cif
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [KW-1:0]    k_q, k_d;

  logic             grant_id;
  logic             idle_ok;
  logic             rdy0, rdy1;
  logic             accept;
  logic             sel_mode;
  logic [WIDTH-1:0] sel_data;
  logic             g_msb_unused;

  // On contention the requester that was not served last wins.
  assign grant_id = (cif.req0_valid & cif.req1_valid) ? ~rr_q : cif.req1_valid;
  assign idle_ok  = rst_n & (state_q == IDLE);
  assign rdy0     = idle_ok & cif.req0_valid & ~grant_id;
  assign rdy1     = idle_ok & cif.req1_valid & grant_id;
  assign accept   = rdy0 | rdy1;
  assign sel_mode = grant_id ? cif.req1_mode : cif.req0_mode;
  assign sel_data = grant_id ? cif.req1_data : cif.req0_data;

  assign cif.req0_ready = rdy0;
  assign cif.req1_ready = rdy1;
  assign cif.out_valid  = (state_q == DONE);
  assign cif.out_id     = id_q;
  assign cif.out_data   = res_q;
  assign cif.busy       = (state_q != IDLE);

  // The MSB of the operand is consumed at accept time, never from the latched copy.
  assign g_msb_unused = g_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    g_d     = g_q;
    res_d   = res_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d = grant_id;
          rr_d = grant_id;
          g_d  = sel_data;
          if (!sel_mode) begin
            res_d   = sel_data ^ (sel_data >> 1);
            state_d = DONE;
          end else begin
            res_d            = '0;
            res_d[WIDTH-1]   = sel_data[WIDTH-1];
            k_d              = (WIDTH > 1) ? KW'(WIDTH - 2) : '0;
            state_d          = (WIDTH == 1) ? DONE : CONV;
          end
        end
      end
      CONV: begin
        // Serial prefix-XOR from MSB down, one bit per cycle.
        for (int i = 0; i < WIDTH - 1; i++) begin
          if (k_q == KW'(i)) begin
            res_d[i] = res_q[i+1] ^ g_q[i];
          end
        end
        if (k_q == '0) begin
          state_d = DONE;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      DONE: begin
        if (cif.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b1;
      id_q    <= 1'b0;
      g_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      g_q     <= g_d;
      res_q   <= res_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_code_conv_sched.sv
// Bench for code_conv_sched: transaction-level model checked every cycle plus directed literal cases.
module tb_code_conv_sched;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  code_conv_sched_if #(.WIDTH(4)) bus4 ();
  code_conv_sched_if #(.WIDTH(1)) bus1 ();

  code_conv_sched #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .cif(bus4));
  code_conv_sched #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .cif(bus1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary value of a Gray word is the XOR of all its right shifts.
  function automatic logic [3:0] to_bin(input logic [3:0] g);
    logic [3:0] b;
    b = '0;
    for (int s = 0; s < 4; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Transaction model: idle/busy, edges left until the result shows, result and owner.
  bit         m_busy;
  bit         m_rr;
  bit         m_id;
  int         m_left;
  logic [3:0] m_data;
  bit         e_r0, e_r1, e_v, m_mode;
  logic [3:0] m_opnd;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_rr   = 1'b1;
      m_id   = 1'b0;
      m_left = 0;
      m_data = 4'h0;
    end
    e_v  = m_busy && (m_left == 0);
    e_r0 = rst_n && !m_busy && bus4.req0_valid && (!bus4.req1_valid || m_rr);
    e_r1 = rst_n && !m_busy && bus4.req1_valid && (!bus4.req0_valid || !m_rr);
    chk("busy", bus4.busy, m_busy);
    chk("out_valid", bus4.out_valid, e_v);
    chk("req0_ready", bus4.req0_ready, e_r0);
    chk("req1_ready", bus4.req1_ready, e_r1);
    chk("out_id", bus4.out_id, m_id);
    if (e_v || !rst_n) chk("out_data", bus4.out_data, m_data);
    if (rst_n) begin
      if (!m_busy) begin
        if (e_r0 || e_r1) begin
          m_id   = e_r1;
          m_rr   = e_r1;
          m_busy = 1'b1;
          m_mode = e_r1 ? bus4.req1_mode : bus4.req0_mode;
          m_opnd = e_r1 ? bus4.req1_data : bus4.req0_data;
          m_data = m_mode ? to_bin(m_opnd) : to_gray(m_opnd);
          m_left = m_mode ? W - 1 : 0;
        end
      end else if (e_v) begin
        if (bus4.out_ready) m_busy = 1'b0;
      end else begin
        m_left--;
      end
    end
  end

  task automatic do_req4(input bit r, input bit m, input logic [3:0] d,
                         output logic [3:0] res, output bit id, output int lat);
    int n;
    @(posedge clk); #1;
    if (r) begin
      bus4.req1_valid = 1'b1; bus4.req1_mode = m; bus4.req1_data = d;
    end else begin
      bus4.req0_valid = 1'b1; bus4.req0_mode = m; bus4.req0_data = d;
    end
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(r ? bus4.req1_ready : bus4.req0_ready) && n < 50);
    chk("req_ready_seen", r ? bus4.req1_ready : bus4.req0_ready, 1'b1);
    @(posedge clk); #1;
    if (r) bus4.req1_valid = 1'b0; else bus4.req0_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end
    while (!bus4.out_valid && lat < 50);
    res = bus4.out_data;
    id  = bus4.out_id;
    @(posedge clk);
  endtask

  logic [3:0] res;
  bit         id;
  int         lat;
  int         n;
  bit         a0, a1;
  bit         got_id[4];
  logic [3:0] got_d[4];
  int         ngot;
  logic [3:0] held_d;
  bit         held_id;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    bus4.req0_valid = 0; bus4.req0_mode = 0; bus4.req0_data = '0;
    bus4.req1_valid = 0; bus4.req1_mode = 0; bus4.req1_data = '0;
    bus4.out_ready  = 1;
    bus1.req0_valid = 0; bus1.req0_mode = 0; bus1.req0_data = '0;
    bus1.req1_valid = 0; bus1.req1_mode = 0; bus1.req1_data = '0;
    bus1.out_ready  = 1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", bus4.out_valid, 1'b0);
    chk("rst_out_data", bus4.out_data, 4'h0);
    chk("rst_out_id", bus4.out_id, 1'b0);
    chk("rst_busy", bus4.busy, 1'b0);
    bus4.req0_valid = 1'b1;
    #1;
    chk("rst_req0_ready", bus4.req0_ready, 1'b0);
    bus4.req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed single requests with hand-computed results.
    do_req4(1'b0, 1'b0, 4'b1011, res, id, lat);
    chk("b2g_1011_data", res, 4'b1110); chk("b2g_1011_id", id, 1'b0); chk("b2g_lat", lat, 1);
    do_req4(1'b1, 1'b1, 4'b1110, res, id, lat);
    chk("g2b_1110_data", res, 4'b1011); chk("g2b_1110_id", id, 1'b1); chk("g2b_lat", lat, 4);
    do_req4(1'b1, 1'b1, 4'b1000, res, id, lat);
    chk("g2b_1000_data", res, 4'b1111);
    do_req4(1'b1, 1'b1, 4'b0000, res, id, lat);
    chk("g2b_0000_data", res, 4'b0000);
    do_req4(1'b0, 1'b1, 4'b1111, res, id, lat);
    chk("g2b_1111_data", res, 4'b1010); chk("g2b_1111_id", id, 1'b0);
    do_req4(1'b0, 1'b0, 4'b1111, res, id, lat);
    chk("b2g_1111_data", res, 4'b1000);

    // Contention straight out of reset: strict alternation starting with requester 0.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    bus4.req0_valid = 1; bus4.req0_mode = 0; bus4.req0_data = 4'b0011;
    bus4.req1_valid = 1; bus4.req1_mode = 1; bus4.req1_data = 4'b0110;
    ngot = 0; n = 0;
    while (ngot < 4 && n < 100) begin
      @(negedge clk); n++;
      if (bus4.out_valid && bus4.out_ready) begin
        got_id[ngot] = bus4.out_id; got_d[ngot] = bus4.out_data; ngot++;
      end
    end
    @(posedge clk); #1;
    bus4.req0_valid = 0; bus4.req1_valid = 0;
    chk("rr_result_count", ngot, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_id", got_id[i], i[0]);
      chk("rr_data", got_d[i], i[0] ? 4'b0100 : 4'b0010);
    end

    // Backpressure: result holds, waiting requester stays unserved until after the handshake.
    @(posedge clk); #1;
    bus4.out_ready = 0;
    bus4.req0_valid = 1; bus4.req0_mode = 0; bus4.req0_data = 4'b0101;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus4.req0_ready && n < 50);
    chk("bp_accept", bus4.req0_ready, 1'b1);
    @(posedge clk); #1;
    bus4.req0_valid = 0;
    bus4.req1_valid = 1; bus4.req1_mode = 0; bus4.req1_data = 4'b1001;
    @(negedge clk);
    chk("bp_valid_first", bus4.out_valid, 1'b1);
    held_d = bus4.out_data; held_id = bus4.out_id;
    chk("bp_data", held_d, 4'b0111); chk("bp_id", held_id, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", bus4.out_valid, 1'b1);
      chk("bp_hold_data", bus4.out_data, 4'b0111);
      chk("bp_hold_id", bus4.out_id, 1'b0);
      chk("bp_no_ready", bus4.req1_ready, 1'b0);
    end
    @(posedge clk); #1 bus4.out_ready = 1;
    @(negedge clk);
    chk("bp_ready_at_hs", bus4.req1_ready, 1'b0);
    @(negedge clk);
    chk("bp_ready_after_hs", bus4.req1_ready, 1'b1);
    @(posedge clk); #1 bus4.req1_valid = 0;
    @(negedge clk);
    chk("bp_next_valid", bus4.out_valid, 1'b1);
    chk("bp_next_data", bus4.out_data, 4'b1101);
    chk("bp_next_id", bus4.out_id, 1'b1);
    @(posedge clk);

    // Reset during a Gray->binary conversion.
    @(posedge clk); #1;
    bus4.req1_valid = 1; bus4.req1_mode = 1; bus4.req1_data = 4'b1110;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus4.req1_ready && n < 50);
    @(posedge clk); #1;
    bus4.req1_valid = 0;
    bus4.req0_valid = 1; bus4.req0_mode = 0; bus4.req0_data = 4'b0001;
    @(posedge clk);
    @(posedge clk); #2;
    chk("mid_busy_before", bus4.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus4.out_valid, 1'b0);
    chk("mid_rst_busy", bus4.busy, 1'b0);
    chk("mid_rst_rdy0", bus4.req0_ready, 1'b0);
    chk("mid_rst_rdy1", bus4.req1_ready, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy0", bus4.req0_ready, 1'b1);
    @(posedge clk); #1 bus4.req0_valid = 0;
    @(negedge clk);
    chk("post_rst_valid", bus4.out_valid, 1'b1);
    chk("post_rst_data", bus4.out_data, 4'b0001);
    chk("post_rst_id", bus4.out_id, 1'b0);
    @(posedge clk);

    // Random traffic against the model; requesters hold their request until accepted.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      a0 = bus4.req0_valid & bus4.req0_ready;
      a1 = bus4.req1_valid & bus4.req1_ready;
      @(posedge clk); #1;
      if (a0) bus4.req0_valid = 0;
      if (a1) bus4.req1_valid = 0;
      if (!bus4.req0_valid && $urandom_range(0, 2) == 0) begin
        bus4.req0_valid = 1; bus4.req0_mode = 1'($urandom); bus4.req0_data = 4'($urandom);
      end
      if (!bus4.req1_valid && $urandom_range(0, 2) == 0) begin
        bus4.req1_valid = 1; bus4.req1_mode = 1'($urandom); bus4.req1_data = 4'($urandom);
      end
      bus4.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    a0 = bus4.req0_valid & bus4.req0_ready;
    a1 = bus4.req1_valid & bus4.req1_ready;
    @(posedge clk); #1;
    if (a0 || a1) begin
      bus4.req0_valid = 0; bus4.req1_valid = 0;
    end else begin
      bus4.req0_valid = 0; bus4.req1_valid = 0;
    end
    bus4.out_ready = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus4.busy && n < 50);
    chk("drain_idle", bus4.busy, 1'b0);

    // WIDTH=1 instance.
    @(posedge clk); #1;
    bus1.req0_valid = 1; bus1.req0_mode = 1; bus1.req0_data = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus1.req0_ready && n < 20);
    chk("w1_rdy0", bus1.req0_ready, 1'b1);
    @(posedge clk); #1 bus1.req0_valid = 0;
    @(negedge clk);
    chk("w1_g2b_valid", bus1.out_valid, 1'b1);
    chk("w1_g2b_data", bus1.out_data, 1'b1);
    chk("w1_g2b_id", bus1.out_id, 1'b0);
    @(posedge clk); #1;
    bus1.req1_valid = 1; bus1.req1_mode = 0; bus1.req1_data = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus1.req1_ready && n < 20);
    chk("w1_rdy1", bus1.req1_ready, 1'b1);
    @(posedge clk); #1 bus1.req1_valid = 0;
    @(negedge clk);
    chk("w1_b2g_valid", bus1.out_valid, 1'b1);
    chk("w1_b2g_data", bus1.out_data, 1'b1);
    chk("w1_b2g_id", bus1.out_id, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("w1_idle", bus1.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
